perf_counter_unit: RTL
======================

# perf_counter_unit

Hardware performance-counter block for the pipelined processor with I/D caches. It sits directly downstream of the processor's retire/memory/cache event signals (register write-back, memory write, halt, fetch and memory-stage cache done/hit). It accumulates cycle, instruction, cache-request, cache-hit and stall counts and freezes them when the processor halts. Software-visible readout is through a registered select/read port.

## Interface
- `CNT_W`, default 32: width of every counter and of `rd_data`; legal range 4..32.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `retire_reg`  in  1  register file write this cycle (write-back stage writeEn).
- `retire_mem`  in  1  qualified data-memory write this cycle (enable & memWrite & ~align_err).
- `halt`  in  1  halt instruction in memory/write-back stage.
- `icache_req`  in  1  fetch-stage cache access done (valid instruction request).
- `icache_hit`  in  1  fetch-stage cache hit.
- `dcache_req`  in  1  memory-stage cache access done.
- `dcache_hit`  in  1  memory-stage cache hit.
- `stall`  in  1  pipeline stall asserted this cycle.
- `clear`  in  1  synchronous clear of all counters, overflow flags and state.
- `rd_sel`  in  3  counter select for readout.
- `rd_data`  out  CNT_W  registered readout of the selected counter.
- `halted`  out  1  high while in FROZEN.
- `ovf`  out  7  sticky saturation flags, bit i belongs to counter i.

## Operation
- Counters by index:
  - 0 cycles
  - 1 instructions
  - 2 icache requests
  - 3 icache hits
  - 4 dcache requests
  - 5 dcache hits
  - 6 stall cycles
  - `rd_sel`=7 reads all zeros.
- State machine: RUN (reset state) and FROZEN.
  - RUN -> FROZEN on the rising edge where `halt`=1 and `clear`=0.
  - FROZEN -> RUN only on `clear`=1.
  - `halt` in FROZEN is ignored.
- In RUN, each rising edge updates the counters as follows:
  - cycles += 1.
  - instructions += 1 if (`retire_reg` | `retire_mem` | `halt`). The increment is 1 even when several of these are high.
  - icache requests += 1 if `icache_req`. icache hits += 1 if `icache_req` & `icache_hit`; a hit without a request is ignored.
  - dcache requests and dcache hits follow the same rules using `dcache_req` and `dcache_hit`.
  - stall cycles += 1 if `stall`.
- The halt cycle itself is counted in both cycles and instructions. In FROZEN no counter changes.
- Saturation: a counter at all-ones does not wrap. It holds all-ones and sets its `ovf` bit on any increment attempt. The `ovf` bits clear only on reset or `clear`.
- `clear` has priority over all events in the same cycle:
  - all counters go to 0, `ovf` goes to 0, state goes to RUN;
  - that cycle's events are dropped, including the cycle count itself.
- Readout: `rd_data` <= counter[`rd_sel`], using the pre-update value sampled at the same edge. It is updated every cycle in both states, so readout works while FROZEN.

## Timing
- Reset (`rst`=0, asynchronous): all counters 0, `rd_data`=0, `ovf`=0, `halted`=0, state RUN. Asserting reset mid-run discards everything immediately, without waiting for a clock edge.
- The first counted edge is the first rising edge with `rst`=1.
- Read latency is 1 cycle: with `rd_sel` set before edge N, `rd_data` after edge N shows the counter value from before edge N's increment.
- `halted` rises after the halt edge. The counters hold their values from that same edge onward.
- `clear` takes effect at the edge where it is sampled. The next edge counts normally.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with all events high. Required: `rd_data`=0, `ovf`=0, `halted`=0. Release reset, then after 10 cycles with all inputs 0, `rd_sel`=0 reads 10.
- Mix: over 8 RUN cycles drive `retire_reg` on cycles 1,2,5; `retire_mem` on cycles 2,6; `icache_req` every cycle; `icache_hit` on 6 of those cycles; `dcache_hit` on cycle 3 without `dcache_req`. Required readouts: instructions=4, icache requests=8, icache hits=6, dcache hits=0, cycles=8.
- Halt: pulse `halt` on cycle 5 and keep all events active for 10 more cycles. Required: cycles=5, instructions include the halt, `halted`=1, and all counters unchanged when read while frozen.
- Saturation, with `CNT_W`=4: run 20 cycles. Required: cycles=15 (0xF) and `ovf[0]`=1. Then assert `clear`: cycles=0 and `ovf`=0.
- Clear collision: assert `clear` together with `halt`, `retire_reg` and `stall`. Required: all counters 0, `halted`=0; after one more idle cycle, cycles=1.
- Asynchronous reset mid-count: drop `rst` between clock edges after 7 cycles. Required: `rd_data` and every counter are 0 before the next edge.

Source files
------------

// File: rtl/perf_counter_unit.sv
// Performance counters for the pipelined core: cycles, instructions, I/D cache
// requests and hits, and stall cycles, frozen on halt and read through a registered port.
module perf_counter_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_reg,
  input  logic             retire_mem,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  input  logic             stall,
  input  logic             clear,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             halted,
  output logic [6:0]       ovf
);

  typedef enum logic {
    RUN,
    FROZEN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [7];
  logic [CNT_W-1:0] cnt_d [7];
  logic [6:0]       ovf_q, ovf_d;
  logic [6:0]       inc;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  // Bit i of inc requests an increment of counter i; hits need a matching request.
  assign inc = {stall,
                dcache_req & dcache_hit,
                dcache_req,
                icache_req & icache_hit,
                icache_req,
                retire_reg | retire_mem | halt,
                1'b1};

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < 7; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (clear) begin
      state_d = RUN;
      ovf_d   = '0;
      for (int i = 0; i < 7; i++) begin
        cnt_d[i] = '0;
      end
    end else if (state_q == RUN) begin
      if (halt) begin
        state_d = FROZEN;
      end
      // Saturate at all-ones instead of wrapping, flagging the lost increment.
      for (int i = 0; i < 7; i++) begin
        if (inc[i]) begin
          if (&cnt_q[i]) begin
            ovf_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end

    case (rd_sel)
      3'd0:    rd_data_d = cnt_q[0];
      3'd1:    rd_data_d = cnt_q[1];
      3'd2:    rd_data_d = cnt_q[2];
      3'd3:    rd_data_d = cnt_q[3];
      3'd4:    rd_data_d = cnt_q[4];
      3'd5:    rd_data_d = cnt_q[5];
      3'd6:    rd_data_d = cnt_q[6];
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      ovf_q     <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < 7; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < 7; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign halted  = (state_q == FROZEN);
  assign ovf     = ovf_q;

endmodule
